// File: rtl/cv32e40x_pkg.sv
// Shared types and helpers for the WB-stage trace buffer.
// A trace record is the retirement snapshot plus its sequence tag.
package cv32e40x_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        illegal;
        logic [15:0] seq;
    } trace_rec_t;

    localparam logic [15:0] CNT16_MAX = 16'hFFFF;

    // Saturating 16-bit increment used by the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == CNT16_MAX) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/cv32e40x_trace_fifo.sv
// Generic synchronous FIFO with registered occupancy and a storage-read head.
// The caller guarantees push only when not full (or with a same-cycle pop) and pop only when not empty.
module cv32e40x_trace_fifo #(
    parameter int  DEPTH = 4,
    parameter type rec_t = logic [80:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  rec_t                     wdata,
    input  logic                     pop,
    output rec_t                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    rec_t          mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_next_s;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        level_next_s = level_r;
        case ({push, pop})
            2'b10:   level_next_s = level_r + LEVEL_ONE;
            2'b01:   level_next_s = level_r - LEVEL_ONE;
            default: level_next_s = level_r;
        endcase
    end

    // Storage, pointers and occupancy; clear drops contents but keeps stale storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_next_s;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (level_r == LEVEL_FULL);
    assign empty = (level_r == '0);
    assign level = level_r;

endmodule

// File: rtl/cv32e40x_wb_trace_buffer.sv
// Captures WB-stage retirements into a trace FIFO with sequence tags and a drop counter.
// Sequence numbers advance on every qualified event, so lost records appear as gaps.
module cv32e40x_wb_trace_buffer
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter bit ILLEGAL_ONLY = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wb_valid_i,
    input  logic [31:0]            wb_pc_i,
    input  logic [31:0]            wb_instr_i,
    input  logic                   wb_illegal_i,
    input  logic                   clear_i,
    output logic                   trace_valid_o,
    input  logic                   trace_ready_i,
    output logic [31:0]            trace_pc_o,
    output logic [31:0]            trace_instr_o,
    output logic                   trace_illegal_o,
    output logic [15:0]            trace_seq_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [15:0]            drop_cnt_o
);

    logic       ev_s;
    logic       pop_s;
    logic       push_s;
    logic       drop_s;
    logic       full_s;
    logic       empty_s;
    logic [15:0] seq_r;
    logic [15:0] drop_cnt_r;
    trace_rec_t wr_rec_s;
    trace_rec_t head_rec_s;

    assign ev_s   = wb_valid_i && (!ILLEGAL_ONLY || wb_illegal_i);
    assign pop_s  = !empty_s && trace_ready_i;
    assign push_s = ev_s && (!full_s || pop_s);
    assign drop_s = ev_s && full_s && !pop_s;

    // Record written at the tail carries the sequence number current at the event.
    always_comb begin
        wr_rec_s         = '0;
        wr_rec_s.pc      = wb_pc_i;
        wr_rec_s.instr   = wb_instr_i;
        wr_rec_s.illegal = wb_illegal_i;
        wr_rec_s.seq     = seq_r;
    end

    cv32e40x_trace_fifo #(
        .DEPTH (DEPTH),
        .rec_t (trace_rec_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (clear_i),
        .push  (push_s),
        .wdata (wr_rec_s),
        .pop   (pop_s),
        .rdata (head_rec_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level_o)
    );

    // Sequence counter ignores clear so flushed events still leave a gap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq_r <= 16'd0;
        end else if (ev_s) begin
            seq_r <= seq_r + 16'd1;
        end else begin
            seq_r <= seq_r;
        end
    end

    // Saturating count of records lost to a full FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_r <= 16'd0;
        end else if (clear_i) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s) begin
            drop_cnt_r <= sat_inc16(drop_cnt_r);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign trace_valid_o   = !empty_s;
    assign trace_pc_o      = head_rec_s.pc;
    assign trace_instr_o   = head_rec_s.instr;
    assign trace_illegal_o = head_rec_s.illegal;
    assign trace_seq_o     = head_rec_s.seq;
    assign drop_cnt_o      = drop_cnt_r;

endmodule
